// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use/branch stalls, and a multi-cycle mult/div stall FSM.
// Optional stall/flush performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_unit #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [4:0]  rs_E,
    input  logic [4:0]  rt_E,
    input  logic [4:0]  writereg_E,
    input  logic [4:0]  writereg_M,
    input  logic [4:0]  writereg_W,
    input  logic        regwrite_E,
    input  logic        regwrite_M,
    input  logic        regwrite_W,
    input  logic        memtoreg_E,
    input  logic        memtoreg_M,
    input  logic        branch_D,
    input  logic        jump_D,
    input  logic        pcsrc_D,
    input  logic        mdstart_E,
    input  logic        mdop_E,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        flush_D,
    output logic        flush_E,
    output logic        forwardA_D,
    output logic        forwardB_D,
    output logic [1:0]  forwardA_E,
    output logic [1:0]  forwardB_E,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
);

    typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;

    // The first stall cycle is spent in IDLE, so the counter covers the remaining N-1.
    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       md_done_q, md_done_d;
    logic       mdstall, lwstall, brstall, hzstall;

    always_comb begin
        forwardA_E = 2'b00;
        if (rs_E != 5'd0 && regwrite_M && writereg_M == rs_E)      forwardA_E = 2'b10;
        else if (rs_E != 5'd0 && regwrite_W && writereg_W == rs_E) forwardA_E = 2'b01;
        forwardB_E = 2'b00;
        if (rt_E != 5'd0 && regwrite_M && writereg_M == rt_E)      forwardB_E = 2'b10;
        else if (rt_E != 5'd0 && regwrite_W && writereg_W == rt_E) forwardB_E = 2'b01;
    end

    assign forwardA_D = (rs_D != 5'd0) && regwrite_M && (writereg_M == rs_D);
    assign forwardB_D = (rt_D != 5'd0) && regwrite_M && (writereg_M == rt_D);

    assign lwstall = memtoreg_E && (rt_E != 5'd0) && ((rt_E == rs_D) || (rt_E == rt_D));
    assign brstall = branch_D &&
        ((regwrite_E && (writereg_E != 5'd0) && ((writereg_E == rs_D) || (writereg_E == rt_D))) ||
         (memtoreg_M && (writereg_M != 5'd0) && ((writereg_M == rs_D) || (writereg_M == rt_D))));
    assign hzstall = lwstall | brstall;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_done_d = 1'b0;
        mdstall   = 1'b0;
        case (state_q)
            IDLE: begin
                // md_done cycle: the finished op is still in Execute and must not relaunch.
                if (mdstart_E && !md_done_q) begin
                    mdstall = 1'b1;
                    state_d = MD_BUSY;
                    cnt_d   = mdop_E ? DIV_LOAD : MULT_LOAD;
                end
            end
            MD_BUSY: begin
                mdstall = 1'b1;
                if (cnt_q == 8'd1) begin
                    state_d   = IDLE;
                    cnt_d     = 8'd0;
                    md_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            md_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_done_q <= md_done_d;
        end
    end

    assign md_busy = (state_q == MD_BUSY);
    assign md_done = md_done_q;

    assign stall_F = mdstall | hzstall;
    assign stall_D = mdstall | hzstall;
    assign stall_E = mdstall;
    assign flush_E = !mdstall && hzstall;
    assign flush_D = !mdstall && (pcsrc_D || jump_D) && !hzstall;

`ifdef HAZARD_PERF_EN
    logic [15:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall_F && perf_stall_q != 16'hFFFF)               perf_stall_d = perf_stall_q + 16'd1;
        if ((flush_D || flush_E) && perf_flush_q != 16'hFFFF)  perf_flush_d = perf_flush_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_q <= 16'd0;
            perf_flush_q <= 16'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = 16'd0;
    assign perf_flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized and directed bench for hazard_unit: a driver pushes reference-model results into a
// queue each cycle and a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_unit;

    localparam int W    = 45;
    localparam int MULT = 4;
    localparam int DIV  = 32;

    typedef struct packed {
        logic [4:0] rs_D, rt_D, rs_E, rt_E, wr_E, wr_M, wr_W;
        logic rw_E, rw_M, rw_W, m2r_E, m2r_M, br_D, j_D, pcsrc, mdstart, mdop, rst_n;
    } stim_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] rs_D = '0, rt_D = '0, rs_E = '0, rt_E = '0;
    logic [4:0] writereg_E = '0, writereg_M = '0, writereg_W = '0;
    logic regwrite_E = 0, regwrite_M = 0, regwrite_W = 0, memtoreg_E = 0, memtoreg_M = 0;
    logic branch_D = 0, jump_D = 0, pcsrc_D = 0, mdstart_E = 0, mdop_E = 0;
    logic stall_F, stall_D, stall_E, flush_D, flush_E, forwardA_D, forwardB_D, md_busy, md_done;
    logic [1:0] forwardA_E, forwardB_E;
    logic [15:0] perf_stall_cnt, perf_flush_cnt;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: position inside a mult/div stall window and pending-done flag.
    int md_pos = 0, md_n = 0;
    bit done_flag = 0;
    int perf_s = 0, perf_f = 0;

    hazard_unit #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
        .writereg_E(writereg_E), .writereg_M(writereg_M), .writereg_W(writereg_W),
        .regwrite_E(regwrite_E), .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
        .memtoreg_E(memtoreg_E), .memtoreg_M(memtoreg_M),
        .branch_D(branch_D), .jump_D(jump_D), .pcsrc_D(pcsrc_D),
        .mdstart_E(mdstart_E), .mdop_E(mdop_E),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
        .flush_D(flush_D), .flush_E(flush_E),
        .forwardA_D(forwardA_D), .forwardB_D(forwardB_D),
        .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
        .md_busy(md_busy), .md_done(md_done),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input stim_t s, output logic [W-1:0] e);
        logic lw, brs, mds, busy, done, hz, sf, sd, se, fd, fe, fad, fbd, next_done;
        logic [1:0] fae, fbe;
        logic [15:0] ps, pf;
        if (!s.rst_n) begin
            md_pos = 0; done_flag = 0; perf_s = 0; perf_f = 0;
        end
        if (s.rs_E != 0 && s.rw_M && s.wr_M == s.rs_E)      fae = 2'b10;
        else if (s.rs_E != 0 && s.rw_W && s.wr_W == s.rs_E) fae = 2'b01;
        else                                                 fae = 2'b00;
        if (s.rt_E != 0 && s.rw_M && s.wr_M == s.rt_E)      fbe = 2'b10;
        else if (s.rt_E != 0 && s.rw_W && s.wr_W == s.rt_E) fbe = 2'b01;
        else                                                 fbe = 2'b00;
        fad = s.rs_D != 0 && s.rw_M && s.wr_M == s.rs_D;
        fbd = s.rt_D != 0 && s.rw_M && s.wr_M == s.rt_D;
        lw  = s.m2r_E && s.rt_E != 0 && (s.rt_E == s.rs_D || s.rt_E == s.rt_D);
        brs = s.br_D && ((s.rw_E && s.wr_E != 0 && (s.wr_E == s.rs_D || s.wr_E == s.rt_D)) ||
                         (s.m2r_M && s.wr_M != 0 && (s.wr_M == s.rs_D || s.wr_M == s.rt_D)));
        hz = lw | brs;
        done = done_flag;
        busy = md_pos > 0;
        mds = 0;
        next_done = 0;
        if (md_pos > 0) begin
            mds = 1;
            md_pos++;
            if (md_pos == md_n) begin
                md_pos = 0;
                next_done = 1;
            end
        end else if (s.mdstart && !done) begin
            mds = 1;
            md_n = s.mdop ? DIV : MULT;
            md_pos = 1;
        end
        if (!s.rst_n) begin
            md_pos = 0;
            next_done = 0;
        end
        if (mds) begin
            sf = 1; sd = 1; se = 1; fd = 0; fe = 0;
        end else begin
            sf = hz; sd = hz; se = 0; fe = hz; fd = (s.pcsrc | s.j_D) & ~hz;
        end
`ifdef HAZARD_PERF_EN
        ps = 16'(perf_s);
        pf = 16'(perf_f);
`else
        ps = 16'd0;
        pf = 16'd0;
`endif
        if (s.rst_n) begin
            if (sf && perf_s < 65535)          perf_s++;
            if ((fd || fe) && perf_f < 65535)  perf_f++;
        end
        done_flag = next_done;
        e = {sf, sd, se, fd, fe, fad, fbd, fae, fbe, busy, done, ps, pf};
    endtask

    task automatic drive(input stim_t s, input string tag);
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        rs_D = s.rs_D; rt_D = s.rt_D; rs_E = s.rs_E; rt_E = s.rt_E;
        writereg_E = s.wr_E; writereg_M = s.wr_M; writereg_W = s.wr_W;
        regwrite_E = s.rw_E; regwrite_M = s.rw_M; regwrite_W = s.rw_W;
        memtoreg_E = s.m2r_E; memtoreg_M = s.m2r_M;
        branch_D = s.br_D; jump_D = s.j_D; pcsrc_D = s.pcsrc;
        mdstart_E = s.mdstart; mdop_E = s.mdop; reset = s.rst_n;
        model_step(s, e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    function automatic stim_t idle_stim();
        stim_t s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, {stall_F, stall_D, stall_E, flush_D, flush_E, forwardA_D, forwardB_D,
                      forwardA_E, forwardB_E, md_busy, md_done, perf_stall_cnt, perf_flush_cnt}, e);
        end
    end

    initial begin
        stim_t s;
        int stall_seen;
        logic [15:0] perf_exp;

        for (int i = 0; i < 3; i++) drive('0, "reset_zero");

        // Forwarding priority: Memory over Writeback, and register 0 never forwards.
        s = idle_stim(); s.rs_E = 5; s.rw_M = 1; s.wr_M = 5; s.rw_W = 1; s.wr_W = 5;
        drive(s, "fwd_mem");
        s.rw_M = 0; drive(s, "fwd_wb");
        s.rs_E = 0; drive(s, "fwd_zero");

        s = idle_stim(); s.m2r_E = 1; s.rt_E = 8; s.rs_D = 8;
        drive(s, "lwstall");
        drive(idle_stim(), "lwstall_gone");

        s = idle_stim(); s.br_D = 1; s.rw_E = 1; s.wr_E = 3; s.rt_D = 3;
        drive(s, "brstall");
        s.pcsrc = 1; drive(s, "brstall_no_flush");
        s = idle_stim(); s.pcsrc = 1; drive(s, "taken_flush");

        // Divide held: 32 stall cycles, done pulse in cycle 33 without relaunch.
        s = idle_stim(); s.mdstart = 1; s.mdop = 1;
        stall_seen = 0;
        for (int i = 0; i < DIV + 1; i++) begin
            drive(s, "div_seq");
            @(negedge clk);
            #1;
            if (stall_E) stall_seen++;
            if (i == DIV) begin
                check("div_done_cycle", {md_done, stall_E}, 2'b10);
            end
        end
        check("div_stall_count", W'(stall_seen), W'(DIV));
        drive(idle_stim(), "div_after");
        drive(idle_stim(), "div_after2");

        // Multiply aborted by reset in its second busy cycle.
        s = idle_stim(); s.mdstart = 1;
        drive(s, "mult_start");
        drive(s, "mult_busy1");
        drive('0, "mult_reset");
        @(negedge clk);
        #1;
        check("mult_reset_now", {stall_F, stall_E, md_busy}, 3'b000);
        drive('0, "mult_reset2");
        for (int i = 0; i < 6; i++) drive(idle_stim(), "mult_no_done");

        for (int i = 0; i < 1500; i++) begin
            s.rs_D = 5'($urandom_range(0, 3)); s.rt_D = 5'($urandom_range(0, 3));
            s.rs_E = 5'($urandom_range(0, 3)); s.rt_E = 5'($urandom_range(0, 3));
            s.wr_E = 5'($urandom_range(0, 3)); s.wr_M = 5'($urandom_range(0, 3));
            s.wr_W = 5'($urandom_range(0, 3));
            s.rw_E = 1'($urandom); s.rw_M = 1'($urandom); s.rw_W = 1'($urandom);
            s.m2r_E = 1'($urandom); s.m2r_M = 1'($urandom); s.br_D = 1'($urandom);
            s.j_D = 1'($urandom); s.pcsrc = 1'($urandom);
            s.mdstart = ($urandom_range(0, 15) == 0); s.mdop = 1'($urandom);
            s.rst_n = ($urandom_range(0, 199) != 0);
            drive(s, $sformatf("rand_%0d", i));
        end

        // Long run of load-use stalls to exercise counter saturation.
        s = idle_stim(); s.m2r_E = 1; s.rt_E = 8; s.rs_D = 8;
        for (int i = 0; i < 70000; i++) drive(s, "perf_sat");
        drive(idle_stim(), "perf_final");
        @(negedge clk);
        #1;
`ifdef HAZARD_PERF_EN
        perf_exp = 16'hFFFF;
`else
        perf_exp = 16'h0000;
`endif
        check("perf_stall_sat", W'(perf_stall_cnt), W'(perf_exp));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 4: total stall cycles for a multiply, legal range 2..255.
REQ-002 SHALL have parameter DIV_CYCLES, default 32: total stall cycles for a divide, legal range 2..255.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have inputs rs_D, rt_D, rs_E, rt_E, writereg_E, writereg_M, writereg_W, each 5 bits: register specifiers per stage.
REQ-006 SHALL have 1-bit inputs regwrite_E, regwrite_M, regwrite_W, memtoreg_E, memtoreg_M, branch_D, jump_D, pcsrc_D: stage control flags.
REQ-007 SHALL have 1-bit inputs mdstart_E (mult/div in Execute) and mdop_E (0 = mult, 1 = div).
REQ-008 SHALL have 1-bit outputs stall_F, stall_D, stall_E: active-high hold of the PC, decode and execute registers (stall_D drives the decode register enable).
REQ-009 SHALL have 1-bit outputs flush_D (decode register clr) and flush_E (execute register clear).
REQ-010 SHALL have outputs forwardA_D, forwardB_D (1 bit each) and forwardA_E, forwardB_E (2 bits each): forwarding mux selects.
REQ-011 SHALL have 1-bit outputs md_busy and md_done, and 16-bit outputs perf_stall_cnt and perf_flush_cnt.

Function
REQ-012 forwardA_E SHALL be 2'b10 if rs_E!=0, regwrite_M=1 and writereg_M==rs_E; else 2'b01 if rs_E!=0, regwrite_W=1 and writereg_W==rs_E; else 2'b00. forwardB_E is the same using rt_E.
REQ-013 forwardA_D SHALL be 1 iff rs_D!=0, regwrite_M=1 and writereg_M==rs_D. forwardB_D is the same using rt_D.
REQ-014 lwstall SHALL be memtoreg_E=1 and rt_E!=0 and (rt_E==rs_D or rt_E==rt_D).
REQ-015 brstall SHALL be branch_D=1 and either (regwrite_E=1, writereg_E!=0, writereg_E matches rs_D or rt_D) or (memtoreg_M=1, writereg_M!=0, writereg_M matches rs_D or rt_D).
REQ-016 The FSM SHALL have two states: IDLE and MD_BUSY. It holds an 8-bit down-counter cnt.
REQ-017 In IDLE with mdstart_E=1 and md_done=0: mdstall=1 in that cycle; at the next edge go to MD_BUSY with cnt = (mdop_E ? DIV_CYCLES : MULT_CYCLES) - 1.
REQ-018 In MD_BUSY: mdstall=1 and cnt decrements each edge; at the edge where cnt==1, go to IDLE, set cnt=0 and set md_done=1.
REQ-019 md_done SHALL be a registered one-cycle pulse; md_busy SHALL be 1 exactly when the state is MD_BUSY.
REQ-020 mdstart_E SHALL be ignored while md_done=1, since the completing instruction is still in Execute; in MD_BUSY it is ignored by construction.
REQ-021 Total stall SHALL be exactly N cycles, where N = MULT_CYCLES or DIV_CYCLES; Execute advances in the md_done cycle.
REQ-022 When mdstall=1: stall_F=stall_D=stall_E=1 and flush_D=flush_E=0, overriding all other hazards.
REQ-023 Otherwise: stall_F=stall_D=lwstall|brstall, stall_E=0, and flush_E=lwstall|brstall (insert a bubble).
REQ-024 Otherwise: flush_D=(pcsrc_D|jump_D) and not (lwstall|brstall); a stalled branch SHALL NOT flush Decode.
REQ-025 The forwarding outputs SHALL be purely combinational and unaffected by stalls.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, cnt=0, md_done=0 and both perf counters to 0, including in the middle of an MD_BUSY sequence.
REQ-027 With all inputs 0 during reset, every output SHALL be 0.

Configuration
REQ-028 With HAZARD_PERF_EN defined: perf_stall_cnt increments on each cycle where stall_F=1, and perf_flush_cnt on each cycle where flush_D|flush_E=1; both saturate at 16'hFFFF.
REQ-029 With HAZARD_PERF_EN undefined: both perf outputs SHALL be tied to 0 and no counter flops SHALL be inferred.

Verification
REQ-030 rs_E=5, regwrite_M=1, writereg_M=5, and regwrite_W=1, writereg_W=5 -> forwardA_E=2'b10; with regwrite_M=0 -> 2'b01; with rs_E=0 -> 2'b00.
REQ-031 memtoreg_E=1, rt_E=8, rs_D=8 -> stall_F=stall_D=flush_E=1, flush_D=0, for one cycle only.
REQ-032 branch_D=1, regwrite_E=1, writereg_E=3, rt_D=3 -> brstall; with pcsrc_D=1 simultaneously -> flush_D=0.
REQ-033 DIV_CYCLES=32, mdstart_E=1, mdop_E=1 held -> stall_F/D/E=1 for exactly 32 cycles, md_done=1 in cycle 33, no restart.
REQ-034 MULT_CYCLES=4, reset pulsed in the 2nd busy cycle -> stalls drop immediately, md_busy=0, md_done never pulses.
REQ-035 HAZARD_PERF_EN defined, 70000 consecutive load-use stalls -> perf_stall_cnt=16'hFFFF; undefined -> 0.
